vload_sequencer: RTL and testbench

// - Vector load engine: fetches LANES consecutive 32-bit words from data memory, one word
//   per handshake, collects them into a lane buffer, then issues a single full-vector write

---
 rtl/vload_sequencer_if.sv | 26 ++
 rtl/vload_sequencer.sv | 133 +++++++++++++
 tb/tb_vload_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vload_sequencer_if.sv
// Memory read port and vector register file write port of the vector load sequencer.
interface vload_sequencer_if #(
  parameter int unsigned LANES = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned RAW   = 4
);
  logic                mem_req;
  logic [AW-1:0]       mem_addr;
  logic                mem_ack;
  logic [DW-1:0]       mem_rdata;
  logic                vrf_we;
  logic                vrf_vector_op;
  logic [RAW-1:0]      vrf_wa;
  logic [LANES*DW-1:0] vrf_wd;

  modport master (
    output mem_req, mem_addr, vrf_we, vrf_vector_op, vrf_wa, vrf_wd,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, vrf_we, vrf_vector_op, vrf_wa, vrf_wd,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/vload_sequencer.sv
// Vector load engine: fetches LANES words from memory, then writes them as one vector register.
// Optional macro VLD_STRIDE_EN adds a runtime byte-stride input (default build: fixed stride 4).
module vload_sequencer #(
  parameter int unsigned LANES = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned RAW   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [RAW-1:0]        dest_reg,
`ifdef VLD_STRIDE_EN
  input  logic [AW-1:0]         stride,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  vload_sequencer_if.master     bus
);

  localparam int unsigned IW = $clog2(LANES);
  localparam int unsigned SW = (LANES > 2) ? $clog2(LANES - 1) : 1;
  localparam logic [IW-1:0]  LastIdx     = IW'(LANES - 1);
  localparam logic [RAW-1:0] RegReserved = '1;

  typedef enum logic [1:0] {StIdle, StFetch, StWrite} state_e;

  state_e              state_q;
  logic [IW-1:0]       idx_q;
  logic [AW-1:0]       addr_q;
  logic [AW-1:0]       stride_q;
  logic [AW-1:0]       stride_in;
  logic [RAW-1:0]      dest_q;
  logic [RAW-1:0]      wa_q;
  logic [LANES*DW-1:0] wd_q;
  logic [LANES*DW-1:0] wd_next;
  logic                busy_q, done_q, err_q, req_q, we_q;
  // Staging buffer for every lane but the last; the last lane goes straight into wd_q.
  logic [DW-1:0]       lane_q [LANES-1];

`ifdef VLD_STRIDE_EN
  assign stride_in = stride;
`else
  assign stride_in = AW'(4);
`endif

  always_comb begin
    wd_next = '0;
    for (int i = 0; i < LANES - 1; i++) begin
      wd_next[i*DW +: DW] = lane_q[i];
    end
    wd_next[(LANES-1)*DW +: DW] = bus.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      dest_q   <= '0;
      wa_q     <= '0;
      wd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      for (int i = 0; i < LANES - 1; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      we_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (dest_reg == RegReserved) begin
              err_q <= 1'b1;
            end else begin
              state_q  <= StFetch;
              busy_q   <= 1'b1;
              req_q    <= 1'b1;
              idx_q    <= '0;
              addr_q   <= base_addr;
              stride_q <= stride_in;
              dest_q   <= dest_reg;
            end
          end
        end
        StFetch: begin
          if (bus.mem_ack) begin
            if (idx_q == LastIdx) begin
              // Whole vector is committed in one step so no partial write is ever visible.
              state_q <= StWrite;
              req_q   <= 1'b0;
              we_q    <= 1'b1;
              done_q  <= 1'b1;
              wa_q    <= dest_q;
              wd_q    <= wd_next;
            end else begin
              lane_q[idx_q[SW-1:0]] <= bus.mem_rdata;
              idx_q                 <= idx_q + IW'(1);
              addr_q                <= addr_q + stride_q;
            end
          end
        end
        StWrite: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          idx_q   <= '0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign bus.mem_req       = req_q;
  assign bus.mem_addr      = addr_q;
  assign bus.vrf_we        = we_q;
  assign bus.vrf_vector_op = we_q;
  assign bus.vrf_wa        = wa_q;
  assign bus.vrf_wd        = wd_q;

endmodule

// File: tb/tb_vload_sequencer.sv
// Bench for vload_sequencer: transaction-level model checked every cycle plus directed literals.
module tb_vload_sequencer;
  localparam int unsigned LANES = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned RAW   = 4;
  localparam int unsigned WDW   = LANES * DW;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [AW-1:0]  base;
  logic [AW-1:0]  stride;
  logic [RAW-1:0] dest;
  logic           ack;
  logic           busy, done, err;

  int total  = 0;
  int bad    = 0;
  int we_cnt = 0;
  bit mon_en = 1'b0;

  vload_sequencer_if #(.LANES(LANES), .DW(DW), .AW(AW), .RAW(RAW)) bus ();

  // Memory: the word stored at byte address A is A itself.
  assign bus.mem_ack   = ack;
  assign bus.mem_rdata = bus.mem_addr;

  vload_sequencer #(.LANES(LANES), .DW(DW), .AW(AW), .RAW(RAW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base),
    .dest_reg  (dest),
`ifdef VLD_STRIDE_EN
    .stride    (stride),
`endif
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WDW-1:0] got, input logic [WDW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Transaction model: what the outputs must show after the next clock edge.
  bit             m_fetch, m_write, m_err, m_zero;
  int             m_idx;
  logic [AW-1:0]  m_base, m_stride;
  logic [RAW-1:0] m_dest;
  logic [DW-1:0]  m_lane [LANES];
  logic [WDW-1:0] m_wd;

  function automatic logic [AW-1:0] lane_addr(input int k);
    return m_base + m_stride * AW'(k);
  endfunction

  initial begin
    m_fetch = 0; m_write = 0; m_err = 0; m_zero = 1; m_idx = 0;
    m_base = '0; m_stride = '0; m_dest = '0; m_wd = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("mon_ctrl", WDW'({busy, done, err, bus.mem_req, bus.vrf_we, bus.vrf_vector_op}),
              WDW'({m_fetch | m_write, m_write, m_err, m_fetch, m_write, m_write}));
        if (m_fetch || m_zero)
          check("mon_addr", WDW'(bus.mem_addr), WDW'(m_fetch ? lane_addr(m_idx) : '0));
        if (m_write || m_zero)
          check("mon_wa", WDW'(bus.vrf_wa), WDW'(m_write ? m_dest : '0));
        check("mon_wd", bus.vrf_wd, m_wd);
        if (bus.vrf_we === 1'b1) we_cnt++;
      end
      if (!reset_n) begin
        m_fetch = 0; m_write = 0; m_err = 0; m_zero = 1; m_idx = 0; m_wd = '0;
      end else begin
        m_err = 0;
        if (m_write) begin
          m_write = 0;
        end else if (m_fetch) begin
          if (ack) begin
            m_lane[m_idx] = lane_addr(m_idx);
            m_idx++;
            if (m_idx == LANES) begin
              m_fetch = 0;
              m_write = 1;
              for (int i = 0; i < LANES; i++) m_wd[i*DW +: DW] = m_lane[i];
            end
          end
        end else if (start) begin
          if (dest == 4'hF) begin
            m_err = 1;
          end else begin
            m_fetch = 1; m_zero = 0; m_idx = 0; m_base = base; m_dest = dest;
`ifdef VLD_STRIDE_EN
            m_stride = stride;
`else
            m_stride = 32'd4;
`endif
          end
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns in cycle 1 of the load (one cycle after the sampling edge).
  task automatic start_load(input logic [AW-1:0] b, input logic [RAW-1:0] d);
    base  = b;
    dest  = d;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_addrs(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] inc);
    logic [AW-1:0] a;
    a = a0;
    for (int k = 0; k < LANES; k++) begin
      check($sformatf("%s_addr%0d", tag, k), WDW'({bus.mem_req, bus.mem_addr}), WDW'({1'b1, a}));
      a = a + inc;
      step();
    end
  endtask

  int w0;
  logic [WDW-1:0] v100, v200, vwrap;

  initial begin
    reset_n = 1'b0; start = 1'b0; base = '0; dest = '0; ack = 1'b1; stride = 32'd4;
    v100  = {32'h110, 32'h10C, 32'h108, 32'h104, 32'h100};
    v200  = {32'h210, 32'h20C, 32'h208, 32'h204, 32'h200};
    vwrap = {32'h8, 32'h4, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8};
    step(2);
    mon_en = 1'b1;
    check("rst_ctrl", WDW'({busy, done, err, bus.mem_req, bus.vrf_we, bus.vrf_vector_op}), '0);
    check("rst_addr", WDW'(bus.mem_addr), '0);
    check("rst_wa", WDW'(bus.vrf_wa), '0);
    check("rst_wd", bus.vrf_wd, '0);
    reset_n = 1'b1;
    step();

    // Contiguous load, ack tied high.
    start_load(32'h100, 4'd3);
    check_addrs("t1", 32'h100, 32'd4);
    check("t1_we_done", WDW'({bus.vrf_we, bus.vrf_vector_op, done}), WDW'(3'b111));
    check("t1_wa", WDW'(bus.vrf_wa), WDW'(4'd3));
    check("t1_wd", bus.vrf_wd, v100);
    step();
    check("t1_idle", WDW'({busy, bus.vrf_we}), '0);

    // Two stall cycles before lane 2.
    start_load(32'h100, 4'd5);
    step(2);
    ack = 1'b0;
    check("t2_addr_c3", WDW'(bus.mem_addr), WDW'(32'h108));
    step();
    check("t2_addr_c4", WDW'(bus.mem_addr), WDW'(32'h108));
    step();
    check("t2_addr_c5", WDW'(bus.mem_addr), WDW'(32'h108));
    ack = 1'b1;
    step(2);
    check("t2_we_c7", WDW'(bus.vrf_we), '0);
    step();
    check("t2_we_c8", WDW'({bus.vrf_we, bus.vrf_wa}), WDW'({1'b1, 4'd5}));
    check("t2_wd", bus.vrf_wd, v100);
    step();

    // Reset after lane 1 is accepted aborts the load.
    w0 = we_cnt;
    start_load(32'h300, 4'd7);
    step(2);
    reset_n = 1'b0;
    step();
    check("t3_rst_ctrl", WDW'({busy, done, err, bus.mem_req, bus.vrf_we, bus.vrf_vector_op}), '0);
    check("t3_rst_addr", WDW'(bus.mem_addr), '0);
    check("t3_rst_wd", bus.vrf_wd, '0);
    reset_n = 1'b1;
    step(8);
    check("t3_no_we", WDW'(we_cnt - w0), '0);
    start_load(32'h200, 4'd2);
    check_addrs("t3", 32'h200, 32'd4);
    check("t3_we", WDW'({bus.vrf_we, bus.vrf_wa}), WDW'({1'b1, 4'd2}));
    check("t3_wd", bus.vrf_wd, v200);
    step();

    // Starts while busy are dropped; a start right after WRITE is taken.
    w0 = we_cnt;
    start_load(32'h180, 4'd4);
    step(2);
    base = 32'h400; dest = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    step(2);
    check("t4_we_c6", WDW'({bus.vrf_we, bus.vrf_wa}), WDW'({1'b1, 4'd4}));
    start = 1'b1;
    step();
    check("t4_idle_c7", WDW'({busy, bus.mem_req}), '0);
    base = 32'h500; dest = 4'd6;
    step();
    start = 1'b0;
    check("t4_req_c8", WDW'({bus.mem_req, bus.mem_addr}), WDW'({1'b1, 32'h500}));
    check("t4_one_we", WDW'(we_cnt - w0), WDW'(1));
    step(5);
    check("t4_we2", WDW'({bus.vrf_we, bus.vrf_wa}), WDW'({1'b1, 4'd6}));
    step();

    // Reserved destination is rejected.
    start_load(32'h700, 4'hF);
    check("t5_err", WDW'({err, busy, bus.mem_req}), WDW'(3'b100));
    step();
    check("t5_err_off", WDW'({err, busy}), '0);

    // Address wrap past the top of the space.
    start_load(32'hFFFF_FFF8, 4'd1);
    check_addrs("t6", 32'hFFFF_FFF8, 32'd4);
    check("t6_wd", bus.vrf_wd, vwrap);
    step();

`ifdef VLD_STRIDE_EN
    stride = 32'h10;
    start_load(32'h40, 4'd8);
    check_addrs("t7", 32'h40, 32'h10);
    check("t7_wd", bus.vrf_wd, {32'h80, 32'h70, 32'h60, 32'h50, 32'h40});
    step();
    stride = 32'h0;
    start_load(32'h40, 4'd9);
    check_addrs("t8", 32'h40, 32'h0);
    check("t8_wd", bus.vrf_wd, {32'h40, 32'h40, 32'h40, 32'h40, 32'h40});
    step();
`endif

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
